sprite_ram_loader: RTL

SPRITE_RAM_LOADER -- requirements
Module: sprite_ram_loader

---
 rtl/sprite_ram_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: streams palette bytes into sprite RAM at consecutive addresses.
// Define SPRITE_RAM_LOADER_RLE_EN to decode (count, index) run-length pairs instead.
module sprite_ram_loader #(
    parameter int R_WIDTH  = 140,
    parameter int R_HEIGHT = 125
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        we,
    output logic [18:0] write_address,
    output logic [7:0]  data_In,
    output logic        busy,
    output logic        done
);
    localparam logic [18:0] LAST = 19'(R_WIDTH * R_HEIGHT - 1);
`ifdef SPRITE_RAM_LOADER_RLE_EN
    typedef enum logic [2:0] {IDLE, GET_CNT, GET_IDX, RUN, DONE} state_t;
    localparam state_t FIRST = GET_CNT;
    logic [7:0] cnt, cnt_n, idx, idx_n;
`else
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    localparam state_t FIRST = STREAM;
`endif
    state_t state, state_n;
    logic [18:0] ptr;
    logic [7:0] wr_data;
    logic wr, acc, at_last;

    assign busy = state != IDLE;
    // Abort withdraws ready so a byte offered in the abort cycle is never consumed.
`ifdef SPRITE_RAM_LOADER_RLE_EN
    assign in_ready = (state == GET_CNT || state == GET_IDX) && !abort;
`else
    assign in_ready = state == STREAM && !abort;
`endif
    assign acc = in_ready && in_valid;
    assign at_last = ptr == LAST;

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        wr = 1'b0;
        wr_data = in_data;
`ifdef SPRITE_RAM_LOADER_RLE_EN
        cnt_n = cnt;
        idx_n = idx;
`endif
        if (busy && abort)
            state_n = IDLE;
        else
            case (state)
                IDLE: state_n = start ? FIRST : IDLE;
`ifdef SPRITE_RAM_LOADER_RLE_EN
                GET_CNT: if (acc) begin
                    cnt_n = in_data;
                    state_n = GET_IDX;
                end
                GET_IDX: if (acc) begin
                    idx_n = in_data;
                    state_n = cnt == 8'd0 ? GET_CNT : RUN;
                end
                RUN: begin
                    wr = 1'b1;
                    wr_data = idx;
                    cnt_n = cnt - 8'd1;
                    state_n = at_last ? DONE : cnt == 8'd1 ? GET_CNT : RUN;
                end
`else
                STREAM: if (acc) begin
                    wr = 1'b1;
                    state_n = at_last ? DONE : STREAM;
                end
`endif
                default: state_n = IDLE;
            endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= '0;
            we <= 1'b0;
            write_address <= '0;
            data_In <= '0;
            done <= 1'b0;
`ifdef SPRITE_RAM_LOADER_RLE_EN
            cnt <= '0;
            idx <= '0;
`endif
        end else begin
            we <= wr;
            done <= wr && at_last;
            if (wr) begin
                write_address <= ptr;
                data_In <= wr_data;
            end
            if (state == IDLE && start)
                ptr <= '0;
            else if (wr && !at_last)
                ptr <= ptr + 19'd1;
`ifdef SPRITE_RAM_LOADER_RLE_EN
            cnt <= cnt_n;
            idx <= idx_n;
`endif
        end
    end
endmodule
